branch_cmp_serial: RTL

- Multi-cycle signed/unsigned comparator and branch-condition resolver for the RV32I branch path.
- Evaluates BEQ/BNE/BLT/BGE/BLTU/BGEU on two operands, scanning DIGIT bits per cycle from the MSB, with early termination.
- Consumes the set-less-than relation rather than producing a single SLT bit: it turns the comparison into a branch-taken decision, using a start/busy/done handshake to the control unit.
- Used where a single-cycle N-bit comparator is too slow or too large.

---
 rtl/branch_cmp_serial_if.sv | 18 +
 rtl/branch_cmp_serial.sv | 88 ++++++++
 2 files changed

// File: rtl/branch_cmp_serial_if.sv
// branch_cmp_serial_if: start/busy/done handshake and operand/result bundle for branch_cmp_serial
//   start, funct3, X, Y          : request from the control unit
//   busy, done                   : progress handshake back to the control unit
//   taken, lt, eq, illegal       : registered branch resolution results
interface branch_cmp_serial_if #(parameter int n = 32);
    logic         start;
    logic [2:0]   funct3;
    logic [n-1:0] X;
    logic [n-1:0] Y;
    logic         busy;
    logic         done;
    logic         taken;
    logic         lt;
    logic         eq;
    logic         illegal;
    modport master (output start, funct3, X, Y, input busy, done, taken, lt, eq, illegal);
    modport slave  (input start, funct3, X, Y, output busy, done, taken, lt, eq, illegal);
endinterface

// File: rtl/branch_cmp_serial.sv
// branch_cmp_serial: multi-cycle RV32I branch comparator scanning DIGIT bits per cycle from the MSB
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of branch_cmp_serial_if (start/funct3/X/Y in, busy/done/taken/lt/eq/illegal out)
module branch_cmp_serial #(
    parameter int n     = 32,
    parameter int DIGIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    branch_cmp_serial_if.slave bus
);
    localparam int NC = n / DIGIT;
    localparam int IW = NC > 1 ? $clog2(NC) : 1;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [n-1:0]   x_q, x_d, y_q, y_d;
    logic [2:0]     f3_q, f3_d;
    logic           taken_q, taken_d, lt_q, lt_d, eq_q, eq_d, ill_q, ill_d;
    logic [DIGIT-1:0] xc, yc;
    logic           sgn, lt_c, eq_c;
    // Signed compare is folded into capture: flipping the sign bits makes an unsigned scan correct.
    assign sgn  = bus.funct3[2:1] == 2'b10;
    assign xc   = DIGIT'(x_q >> (n - DIGIT - DIGIT * int'(idx_q)));
    assign yc   = DIGIT'(y_q >> (n - DIGIT - DIGIT * int'(idx_q)));
    assign lt_c = xc < yc;
    assign eq_c = xc == yc;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        f3_d    = f3_q;
        taken_d = taken_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        ill_d   = ill_q;
        if (state_q == SCAN) begin
            if (!eq_c || idx_q == IW'(NC - 1)) begin
                state_d = DONE;
                lt_d    = lt_c;
                eq_d    = eq_c;
                ill_d   = !f3_q[2] && f3_q[1];
                taken_d = f3_q[2] ? lt_c ^ f3_q[0] : (f3_q[1] ? 1'b0 : eq_c ^ f3_q[0]);
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else if (bus.start) begin
            state_d = SCAN;
            idx_d   = '0;
            x_d     = bus.X ^ {sgn, {(n-1){1'b0}}};
            y_d     = bus.Y ^ {sgn, {(n-1){1'b0}}};
            f3_d    = bus.funct3;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            f3_q    <= '0;
            taken_q <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            f3_q    <= f3_d;
            taken_q <= taken_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            ill_q   <= ill_d;
        end
    end
    assign bus.busy    = state_q == SCAN;
    assign bus.done    = state_q == DONE;
    assign bus.taken   = taken_q;
    assign bus.lt      = lt_q;
    assign bus.eq      = eq_q;
    assign bus.illegal = ill_q;
endmodule
